// File: rtl/fp32_mul_responder_if.sv
// fp32_mul_responder_if: stb/ack operand channels A, B and product channel Z; master = initiator, slave = multiplier
interface fp32_mul_responder_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;
  modport master (
    output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );
  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/fp32_mul_responder.sv
// fp32_mul_responder: fp32 multiplier (RNE, subnormals flushed) on stb/ack; ports clk, reset (sync, high), bus (slave: A, B in; Z out)
module fp32_mul_responder (
  input logic                 clk,
  input logic                 reset,
  fp32_mul_responder_if.slave bus
);
  typedef enum logic [2:0] {GET_A, GET_B, UNPACK, SPECIAL, MUL, NORM, ROUND, PUT_Z} state_t;
  state_t state_q, state_d;
  logic a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
  logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic s_q, s_d;
  logic [7:0] ea_q, ea_d, eb_q, eb_d;
  logic [23:0] ma_q, ma_d, mb_q, mb_d;
  logic [47:0] p_q, p_d;
  logic signed [9:0] e_q, e_d;
  logic [22:0] m_q, m_d;
  logic g_q, g_d, st_q, st_d;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_nan, is_inf, special;
  logic inc;
  logic [23:0] mr;
  logic signed [9:0] er;
  assign a_nan   = ea_q == 8'hff && ma_q[22:0] != 23'd0;
  assign b_nan   = eb_q == 8'hff && mb_q[22:0] != 23'd0;
  assign a_inf   = ea_q == 8'hff && ma_q[22:0] == 23'd0;
  assign b_inf   = eb_q == 8'hff && mb_q[22:0] == 23'd0;
  assign a_zero  = ea_q == 8'd0;
  assign b_zero  = eb_q == 8'd0;
  assign is_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  assign is_inf  = a_inf | b_inf;
  assign special = is_nan | is_inf | a_zero | b_zero;
  assign inc = g_q & (st_q | m_q[0]);
  assign mr  = {1'b0, m_q} + {23'd0, inc};
  assign er  = e_q + $signed({9'd0, mr[23]});
  assign bus.input_a_ack  = a_ack_q;
  assign bus.input_b_ack  = b_ack_q;
  assign bus.output_z     = z_q;
  assign bus.output_z_stb = z_stb_q;
  always_comb begin
    state_d = state_q;
    a_ack_d = a_ack_q;
    b_ack_d = b_ack_q;
    z_stb_d = z_stb_q;
    a_d = a_q;
    b_d = b_q;
    z_d = z_q;
    s_d = s_q;
    ea_d = ea_q;
    eb_d = eb_q;
    ma_d = ma_q;
    mb_d = mb_q;
    p_d = p_q;
    e_d = e_q;
    m_d = m_q;
    g_d = g_q;
    st_d = st_q;
    case (state_q)
      GET_A: begin
        a_ack_d = !(a_ack_q && bus.input_a_stb);
        if (a_ack_q && bus.input_a_stb) begin
          a_d = bus.input_a;
          b_ack_d = 1'b1;
          state_d = GET_B;
        end
      end
      GET_B: begin
        b_ack_d = !(b_ack_q && bus.input_b_stb);
        if (b_ack_q && bus.input_b_stb) begin
          b_d = bus.input_b;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        s_d = a_q[31] ^ b_q[31];
        ea_d = a_q[30:23];
        eb_d = b_q[30:23];
        ma_d = a_q[30:23] == 8'd0 ? 24'd0 : {1'b1, a_q[22:0]};
        mb_d = b_q[30:23] == 8'd0 ? 24'd0 : {1'b1, b_q[22:0]};
        state_d = SPECIAL;
      end
      SPECIAL: begin
        z_d = !special ? z_q : is_nan ? 32'h7fc00000 : is_inf ? {s_q, 8'hff, 23'd0} : {s_q, 31'd0};
        z_stb_d = special;
        state_d = special ? PUT_Z : MUL;
      end
      MUL: begin
        p_d = {24'd0, ma_q} * {24'd0, mb_q};
        e_d = $signed({2'd0, ea_q}) + $signed({2'd0, eb_q}) - 10'sd127;
        state_d = NORM;
      end
      NORM: begin
        m_d = p_q[47] ? p_q[46:24] : p_q[45:23];
        g_d = p_q[47] ? p_q[23] : p_q[22];
        st_d = p_q[47] ? |p_q[22:0] : |p_q[21:0];
        e_d = e_q + $signed({9'd0, p_q[47]});
        state_d = ROUND;
      end
      ROUND: begin
        z_d = er >= 10'sd255 ? {s_q, 8'hff, 23'd0} : er <= 10'sd0 ? {s_q, 31'd0} : {s_q, er[7:0], mr[22:0]};
        z_stb_d = 1'b1;
        state_d = PUT_Z;
      end
      PUT_Z: begin
        z_stb_d = !bus.output_z_ack;
        state_d = bus.output_z_ack ? GET_A : PUT_Z;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GET_A;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
      z_q <= 32'd0;
    end else begin
      state_q <= state_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      z_stb_q <= z_stb_d;
      z_q <= z_d;
    end
    a_q <= a_d;
    b_q <= b_d;
    s_q <= s_d;
    ea_q <= ea_d;
    eb_q <= eb_d;
    ma_q <= ma_d;
    mb_q <= mb_d;
    p_q <= p_d;
    e_q <= e_d;
    m_q <= m_d;
    g_q <= g_d;
    st_q <= st_d;
  end
endmodule

// File: tb/tb_fp32_mul_responder.sv
// tb_fp32_mul_responder: directed and random fp32 products checked against an arithmetic reference model
module tb_fp32_mul_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  fp32_mul_responder_if bus();
  fp32_mul_responder dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    longint unsigned p, q, rem, half;
    logic an, bn, ai, bi, az, bz;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = ea == 255 && a[22:0] != 0;
    bn = eb == 255 && b[22:0] != 0;
    ai = ea == 255 && a[22:0] == 0;
    bi = eb == 255 && b[22:0] == 0;
    az = ea == 0;
    bz = eb == 0;
    if (an || bn || (ai && bz) || (bi && az)) return {1'b1, 32'h7fc00000};
    if (ai || bi) return {1'b1, s, 8'hff, 23'd0};
    if (az || bz) return {1'b1, s, 31'd0};
    p = (64'(a[22:0]) + (64'd1 << 23)) * (64'(b[22:0]) + (64'd1 << 23));
    e = ea + eb - 127;
    sh = p >= (64'd1 << 47) ? 24 : 23;
    e += sh - 23;
    q = p >> sh;
    rem = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e++;
    end
    if (e >= 255) return {1'b0, s, 8'hff, 23'd0};
    if (e <= 0) return {1'b0, s, 31'd0};
    return {1'b0, s, 8'(e), q[22:0]};
  endfunction
  task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [32:0] r;
    logic [31:0] z0;
    int n, lat;
    r = ref_mul(a, b);
    bus.input_a = a;
    bus.input_b = b;
    bus.input_a_stb = 1'b1;
    bus.input_b_stb = 1'b1;
    n = 0;
    while (!bus.input_a_ack && n < 50) begin
      step();
      n++;
    end
    check({tag, ":a_ack"}, 64'(bus.input_a_ack), 64'd1);
    step();
    bus.input_a_stb = 1'b0;
    check({tag, ":b_ack_after_a"}, 64'({bus.input_a_ack, bus.input_b_ack}), 64'b01);
    step();
    bus.input_b_stb = 1'b0;
    lat = 1;
    while (!bus.output_z_stb && lat < 50) begin
      step();
      lat++;
    end
    check({tag, ":latency"}, 64'(lat), r[32] ? 64'd3 : 64'd6);
    check({tag, ":z"}, 64'(bus.output_z), 64'(r[31:0]));
    z0 = bus.output_z;
    for (int i = 0; i < hold; i++) begin
      bus.input_a_stb = 1'b1;
      bus.input_a = $urandom;
      step();
      check({tag, ":hold"}, 64'({bus.output_z, bus.output_z_stb, bus.input_a_ack, bus.input_b_ack}), 64'({z0, 3'b100}));
    end
    bus.input_a_stb = 1'b0;
    bus.output_z_ack = 1'b1;
    step();
    bus.output_z_ack = 1'b0;
    check({tag, ":z_released"}, 64'({bus.output_z_stb, bus.input_a_ack}), 64'd0);
    step();
    check({tag, ":a_ack_next"}, 64'(bus.input_a_ack), 64'd1);
  endtask
  initial begin
    logic [31:0] ra, rb;
    int n;
    bus.input_a = 32'd0;
    bus.input_b = 32'd0;
    bus.input_a_stb = 1'b0;
    bus.input_b_stb = 1'b0;
    bus.output_z_ack = 1'b0;
    repeat (3) step();
    check("reset_state", 64'({bus.input_a_ack, bus.input_b_ack, bus.output_z_stb, bus.output_z}), 64'd0);
    reset = 1'b0;
    check("a_ack_before_edge", 64'(bus.input_a_ack), 64'd0);
    step();
    check("a_ack_after_reset", 64'(bus.input_a_ack), 64'd1);
    xfer("basic_1.5sq", 32'h3fc00000, 32'h3fc00000, 0);
    xfer("rne_lsb", 32'h3f800001, 32'h3f800001, 0);
    xfer("two_x_three", 32'h40000000, 32'h40400000, 0);
    xfer("neg_two_x_three", 32'hc0000000, 32'h40400000, 0);
    xfer("inf_x_zero", 32'h7f800000, 32'h00000000, 0);
    xfer("zero_x_inf", 32'h00000000, 32'hff800000, 0);
    xfer("nan", 32'h7fc00001, 32'h3f800000, 0);
    xfer("neg_inf", 32'hff800000, 32'h40000000, 0);
    xfer("overflow", 32'h7f000000, 32'h7f000000, 0);
    xfer("underflow", 32'h80800000, 32'h00800000, 0);
    xfer("subnormal", 32'h00000001, 32'h3f800000, 0);
    xfer("round_carry", 32'h3fffffff, 32'h3fffffff, 0);
    xfer("backpressure", 32'h3fc00000, 32'h3fc00000, 10);
    bus.input_a = 32'h3fc00000;
    bus.input_b = 32'h3fc00000;
    bus.input_a_stb = 1'b1;
    bus.input_b_stb = 1'b1;
    n = 0;
    while (!bus.input_a_ack && n < 50) begin
      step();
      n++;
    end
    step();
    bus.input_a_stb = 1'b0;
    step();
    bus.input_b_stb = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    check("mid_reset_outputs", 64'({bus.input_a_ack, bus.input_b_ack, bus.output_z_stb, bus.output_z}), 64'd0);
    reset = 1'b0;
    step();
    check("mid_reset_a_ack", 64'({bus.input_a_ack, bus.output_z_stb}), 64'b10);
    xfer("after_reset", 32'h3fc00000, 32'h3fc00000, 0);
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 != 3) begin
        ra[30:23] = 8'($urandom_range(90, 165));
        rb[30:23] = 8'($urandom_range(90, 165));
      end
      xfer($sformatf("rand%0d", i), ra, rb, int'($urandom_range(0, 2)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
